// File: rtl/mc_ctrl_unit_hs.sv
// rtl/mc_ctrl_unit_hs.sv - multi-cycle RV32 controller with IMem/DMem ready handshakes and wait timeout
// Optional performance counters enabled by defining CTRL_PERF_CNT_EN.
module mc_ctrl_unit_hs #(
  parameter int LANES    = 4,
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             is_fence,
  input  logic             is_system,
  input  logic [LANES-1:0] decoder_dmem_we,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             resume,
  output logic             pc_we,
  output logic             imem_rd,
  output logic             ir_we,
  output logic             rf_we,
  output logic             dmem_rd,
  output logic [LANES-1:0] dmem_we,
  output logic             halted,
  output logic             bus_err,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] instret,
  output logic [CNT_W-1:0] stall_cnt,
`endif
  output logic [2:0]       state_o
);

  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LIM = CW'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_IDEX = 3'd1,
    S_MEM  = 3'd2,
    S_WB   = 3'd3,
    S_HALT = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout;

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IF;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A ready in the timeout cycle still wins because it is tested first.
  assign timeout = (WAIT_MAX > 0) && (cnt_q == WAIT_LIM);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IF: begin
        if (imem_ready)   state_d = S_IDEX;
        else if (timeout) state_d = S_ERR;
        else              cnt_d   = cnt_q + CW'(1);
      end
      S_IDEX: begin
        if (is_system)                state_d = S_HALT;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready)   state_d = S_WB;
        else if (timeout) state_d = S_ERR;
        else              cnt_d   = cnt_q + CW'(1);
      end
      S_WB:    state_d = S_IF;
      S_HALT:  if (resume) state_d = S_WB;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IF;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    pc_we   = 1'b0;
    imem_rd = 1'b0;
    ir_we   = 1'b0;
    rf_we   = 1'b0;
    dmem_rd = 1'b0;
    dmem_we = '0;
    halted  = 1'b0;
    bus_err = 1'b0;
    state_o = state_q;
    case (state_q)
      S_IF: begin
        imem_rd = 1'b1;
        ir_we   = imem_ready;
      end
      S_MEM: begin
        dmem_rd = is_load;
        dmem_we = is_store ? decoder_dmem_we : '0;
      end
      S_WB: begin
        pc_we = 1'b1;
        rf_we = !(is_store || is_branch || is_fence || is_system);
      end
      S_HALT:  halted  = 1'b1;
      S_ERR:   bus_err = 1'b1;
      default: ;
    endcase
    // Reset gates outputs immediately, dropping any in-flight DMem write.
    if (!rstn) begin
      pc_we   = 1'b0;
      imem_rd = 1'b0;
      ir_we   = 1'b0;
      rf_we   = 1'b0;
      dmem_rd = 1'b0;
      dmem_we = '0;
      halted  = 1'b0;
      bus_err = 1'b0;
      state_o = 3'd0;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instret_q <= '0;
      stall_q   <= '0;
    end else begin
      instret_q <= instret_d;
      stall_q   <= stall_d;
    end
  end

  always_comb begin
    instret_d = instret_q;
    stall_d   = stall_q;
    if (state_q == S_WB) instret_d = instret_q + CNT_W'(1);
    if ((state_q == S_IF && !imem_ready) || (state_q == S_MEM && !dmem_ready))
      stall_d = stall_q + CNT_W'(1);
  end

  assign instret   = instret_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_unit_hs.sv
// tb/tb_mc_ctrl_unit_hs.sv - directed and randomized bench for mc_ctrl_unit_hs against an instruction-level model
module tb_mc_ctrl_unit_hs;

  localparam int WMAX  = 4;
  localparam int CNT_W = 32;

  logic       clk = 1'b0;
  logic       rstn;
  logic       is_load, is_store, is_branch, is_fence, is_system;
  logic [3:0] decoder_dmem_we;
  logic       imem_ready, dmem_ready, resume;
  logic       pc_we, imem_rd, ir_we, rf_we, dmem_rd, halted, bus_err;
  logic [3:0] dmem_we;
  logic [2:0] state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] instret, stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int exp_instret = 0;
  int exp_stall = 0;

  mc_ctrl_unit_hs #(.LANES(4), .WAIT_MAX(WMAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .is_fence(is_fence), .is_system(is_system),
    .decoder_dmem_we(decoder_dmem_we),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .resume(resume),
    .pc_we(pc_we), .imem_rd(imem_rd), .ir_we(ir_we), .rf_we(rf_we),
    .dmem_rd(dmem_rd), .dmem_we(dmem_we), .halted(halted), .bus_err(bus_err),
`ifdef CTRL_PERF_CNT_EN
    .instret(instret), .stall_cnt(stall_cnt),
`endif
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs packed as {pc_we,imem_rd,ir_we,rf_we,dmem_rd,dmem_we,halted,bus_err}.
  task automatic expect_cyc(input string tag, input logic [2:0] st, input logic [10:0] outs);
    @(negedge clk);
    chk({tag, "_state"}, {29'd0, state_o}, {29'd0, st});
    chk({tag, "_outs"}, {21'd0, pc_we, imem_rd, ir_we, rf_we, dmem_rd, dmem_we, halted, bus_err},
        {21'd0, outs});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    chk("rst_state", {29'd0, state_o}, 32'd0);
    chk("rst_outs", {21'd0, pc_we, imem_rd, ir_we, rf_we, dmem_rd, dmem_we, halted, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_instret = 0;
    exp_stall = 0;
  endtask

  task automatic check_err(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom);
      resume     = 1'($urandom);
      expect_cyc("err", 3'd5, 11'b0000_0_0000_0_1);
    end
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 branch, 4 fence, 5 system
  task automatic run_instr(input int kind, input int iw, input int dw, input logic [3:0] mask,
                           input int hold, output bit err);
    logic rf_exp;
    err = 1'b0;
    is_load = (kind == 1); is_store = (kind == 2); is_branch = (kind == 3);
    is_fence = (kind == 4); is_system = (kind == 5);
    decoder_dmem_we = mask;
    rf_exp = (kind == 0) || (kind == 1);
    for (int c = 0; c <= WMAX; c++) begin
      imem_ready = (c >= iw);
      dmem_ready = 1'($urandom);
      resume     = 1'($urandom);
      if (!imem_ready) exp_stall++;
      expect_cyc("if", 3'd0, {1'b0, 1'b1, imem_ready, 1'b0, 1'b0, 4'b0, 1'b0, 1'b0});
      if (imem_ready) break;
      if (c == WMAX) begin err = 1'b1; return; end
    end
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    resume     = 1'($urandom);
    expect_cyc("idex", 3'd1, 11'd0);
    if (kind == 5) begin
      for (int h = 0; h <= hold; h++) begin
        resume = (h == hold);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        expect_cyc("halt", 3'd4, 11'b0000_0_0000_1_0);
      end
    end else if (kind == 1 || kind == 2) begin
      for (int c = 0; c <= WMAX; c++) begin
        dmem_ready = (c >= dw);
        imem_ready = 1'($urandom);
        resume     = 1'($urandom);
        if (!dmem_ready) exp_stall++;
        expect_cyc("mem", 3'd2, {4'b0000, (kind == 1), (kind == 2) ? mask : 4'b0000, 2'b00});
        if (dmem_ready) break;
        if (c == WMAX) begin err = 1'b1; return; end
      end
    end
    imem_ready = 1'($urandom);
    dmem_ready = 1'($urandom);
    resume     = 1'($urandom);
    exp_instret++;
    expect_cyc("wb", 3'd3, {1'b1, 1'b0, 1'b0, rf_exp, 1'b0, 4'b0, 2'b00});
  endtask

`ifdef CTRL_PERF_CNT_EN
  task automatic chk_perf(input string tag);
    chk({tag, "_instret"}, instret, exp_instret);
    chk({tag, "_stall"}, stall_cnt, exp_stall);
  endtask
`endif

  initial begin
    bit e;
    rstn = 1'b0;
    {is_load, is_store, is_branch, is_fence, is_system} = '0;
    decoder_dmem_we = '0;
    imem_ready = 1'b0; dmem_ready = 1'b0; resume = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    run_instr(0, 0, 0, 4'h0, 0, e);
    run_instr(2, 0, 2, 4'b0011, 0, e);
    run_instr(1, 0, 99, 4'h0, 0, e);
    if (e) begin check_err(4); do_reset(); end
    run_instr(5, 0, 0, 4'h0, 10, e);
    run_instr(0, 0, 0, 4'h0, 0, e);

    // Reset during a store's MEM wait must drop the write within the cycle.
    {is_load, is_store, is_branch, is_fence, is_system} = 5'b01000;
    decoder_dmem_we = 4'b1010;
    imem_ready = 1'b1; dmem_ready = 1'b0; resume = 1'b0;
    expect_cyc("mr_if", 3'd0, 11'b0110_0_0000_0_0);
    expect_cyc("mr_idex", 3'd1, 11'd0);
    @(negedge clk);
    chk("mr_we_before", {28'd0, dmem_we}, 32'ha);
    #1;
    rstn = 1'b0;
    #1;
    chk("mr_we_reset", {28'd0, dmem_we}, 32'h0);
    chk("mr_state_reset", {29'd0, state_o}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    exp_instret = 0; exp_stall = 0;
    @(negedge clk);
    chk("mr_state_after", {29'd0, state_o}, 32'd0);
    chk("mr_imem_rd_after", {31'd0, imem_rd}, 32'd1);
    @(posedge clk);
    #1;

    do_reset();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 0, 4'h0, 0, e);
    run_instr(1, 2, 0, 4'h0, 0, e);
`ifdef CTRL_PERF_CNT_EN
    chk_perf("perf_plan");
`endif

    for (int i = 0; i < 60; i++) begin
      int kind, iw, dw;
      kind = $urandom_range(0, 5);
      iw = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 3);
      dw = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
      run_instr(kind, iw, dw, 4'($urandom), $urandom_range(0, 3), e);
`ifdef CTRL_PERF_CNT_EN
      chk_perf("perf_rand");
`endif
      if (e) begin check_err(3); do_reset(); end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
